// File: rtl/writeback_unit.sv
// Register-bank write port driver: boot sweep of all registers after reset,
// then registered write-back of retiring results with a forwarding tap.
module writeback_unit #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NREGS      = 32,
    parameter bit          INIT_INDEX = 1'b1,
    parameter bit          PROTECT_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [DATA_W-1:0] wb_mem_data,
    output logic              we_RF,
    output logic [4:0]        A3,
    output logic [DATA_W-1:0] WD3,
    output logic              init_done,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     counter;
    logic [AW-1:0]     counter_nxt;
    logic              we_nxt;
    logic [4:0]        a3_nxt;
    logic [DATA_W-1:0] wd3_nxt;
    logic              init_done_nxt;
    logic              accept;
    logic              do_write;
    logic              sweep_last;

    assign wb_ready   = (state == S_RUN);
    assign accept     = wb_valid && wb_ready;
    assign do_write   = accept && wb_reg_write && !(PROTECT_R0 && (wb_rd == 5'd0));
    assign sweep_last = (counter == AW'(NREGS - 1));

    // Decode reads the value being written this cycle through the tap.
    assign fwd_valid = we_RF;
    assign fwd_rd    = A3;
    assign fwd_data  = WD3;

    // State and registered outputs; reset restarts the sweep from register 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            counter   <= '0;
            we_RF     <= 1'b0;
            A3        <= 5'd0;
            WD3       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            counter   <= counter_nxt;
            we_RF     <= we_nxt;
            A3        <= a3_nxt;
            WD3       <= wd3_nxt;
            init_done <= init_done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        case (state)
            S_INIT: begin
                counter_nxt = counter + AW'(1);
                if (sweep_last) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                state_nxt = S_RUN;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Next values of the registered write port; address and data hold when idle.
    always_comb begin
        we_nxt        = 1'b0;
        a3_nxt        = A3;
        wd3_nxt       = WD3;
        init_done_nxt = init_done;
        case (state)
            S_INIT: begin
                we_nxt  = 1'b1;
                a3_nxt  = 5'(counter);
                wd3_nxt = INIT_INDEX ? DATA_W'(counter) : '0;
                if (sweep_last) begin
                    init_done_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (do_write) begin
                    we_nxt  = 1'b1;
                    a3_nxt  = wb_rd;
                    wd3_nxt = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
                end
            end
            default: begin
                we_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: boot sweep, reset mid-sweep,
// directed write-back vectors and randomized traffic against a reference model.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic        we_RF;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        init_done;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int n_cmp = 0;
    int n_bad = 0;

    writeback_unit #(
        .DATA_W(32), .NREGS(32), .INIT_INDEX(1'b1), .PROTECT_R0(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .we_RF(we_RF), .A3(A3), .WD3(WD3), .init_done(init_done),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic        exp_we;
        logic [4:0]  exp_a3;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [4:0] a3,
                            input logic [31:0] wd);
        chk({tag, ".we_RF"}, 32'(we_RF), 32'(we));
        chk({tag, ".A3"}, 32'(A3), 32'(a3));
        chk({tag, ".WD3"}, WD3, wd);
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(we));
        chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(a3));
        chk({tag, ".fwd_data"}, fwd_data, wd);
    endtask

    // Full 32-register boot sweep starting from the current cycle.
    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            step();
            chk_port(tag, 1'b1, 5'(i), 32'(i));
            if (i < 31) begin
                chk({tag, ".init_done_low"}, 32'(init_done), 32'd0);
                chk({tag, ".ready_low"}, 32'(wb_ready), 32'd0);
            end
        end
        chk({tag, ".init_done_high"}, 32'(init_done), 32'd1);
        chk({tag, ".ready_high"}, 32'(wb_ready), 32'd1);
    endtask

    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic        m_we;

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_reg_write = 1'b0; wb_mem_to_reg = 1'b0;
        wb_rd = 5'd0; wb_alu_result = 32'd0; wb_mem_data = 32'd0;

        // Reset state held for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_port("reset", 1'b0, 5'd0, 32'd0);
            chk("reset.init_done", 32'(init_done), 32'd0);
            chk("reset.ready", 32'(wb_ready), 32'd0);
        end
        rst = 1'b0;
        sweep("boot");
        step();
        chk_port("boot_idle", 1'b0, 5'd31, 32'd31);
        chk("boot_idle.init_done", 32'(init_done), 32'd1);

        // Reset asserted while A3=17 restarts the sweep from register 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step();
            chk_port("partial", 1'b1, 5'(i), 32'(i));
        end
        rst = 1'b1;
        step();
        chk_port("midreset", 1'b0, 5'd0, 32'd0);
        chk("midreset.init_done", 32'(init_done), 32'd0);
        rst = 1'b0;
        sweep("resweep");

        // Directed write-back vectors; A3/WD3 hold on non-writes.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'h12345678, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 32'h12345678, 1'b1, 5'd5,  32'h12345678};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 5'd1,  32'h0000000A, 32'h0,        1'b1, 5'd1,  32'h0000000A};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 5'd2,  32'h0000000B, 32'h0,        1'b1, 5'd2,  32'h0000000B};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 5'd3,  32'h0000000C, 32'h0,        1'b1, 5'd3,  32'h0000000C};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd0,  32'h00000077, 32'h0,        1'b0, 5'd3,  32'h0000000C};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 5'd9,  32'h00000099, 32'h0,        1'b0, 5'd3,  32'h0000000C};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 5'd7,  32'h00000055, 32'h0,        1'b0, 5'd3,  32'h0000000C};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 5'd31, 32'h0,        32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
        for (int i = 0; i < 9; i++) begin
            wb_valid = vecs[i].valid; wb_reg_write = vecs[i].rw; wb_mem_to_reg = vecs[i].m2r;
            wb_rd = vecs[i].rd; wb_alu_result = vecs[i].alu; wb_mem_data = vecs[i].mem;
            step();
            chk_port($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_a3, vecs[i].exp_wd);
        end

        // Randomized traffic in RUN against a behavioural model of the write port.
        m_a3 = 5'd31;
        m_wd = 32'hFFFFFFFF;
        for (int i = 0; i < 300; i++) begin
            wb_valid      = 1'($urandom);
            wb_reg_write  = 1'($urandom);
            wb_mem_to_reg = 1'($urandom);
            wb_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wb_alu_result = $urandom;
            wb_mem_data   = $urandom;
            m_we = wb_valid && wb_reg_write && (wb_rd != 5'd0);
            if (m_we) begin
                m_a3 = wb_rd;
                m_wd = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
            end
            step();
            chk_port("rand", m_we, m_a3, m_wd);
        end

        // Valid held across reset and boot: dropped in the reset cycle, written after init.
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_mem_to_reg = 1'b0;
        wb_rd = 5'd12; wb_alu_result = 32'h000055AA; wb_mem_data = 32'h0;
        rst = 1'b1;
        step();
        chk_port("rst_valid", 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        sweep("held");
        step();
        chk_port("held_write", 1'b1, 5'd12, 32'h000055AA);
        wb_valid = 1'b0;
        step();
        chk_port("held_after", 1'b0, 5'd12, 32'h000055AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
